cw_div_meter: RTL and testbench

Clock-ratio meter: the receiving end of the even clock divider. Samples a divided clock `i_Sig` in the `i_Clk` domain and recovers its division ratio (period in `i_Clk` cycles) and high time. Flags lock when the ratio is stable and timeout when edges stop. Used by the clock's self-test path to confirm that each divided tick clock runs at its programmed ratio.

---
 rtl/cw_div_pkg.sv | 20 ++
 rtl/cw_edge_detect.sv | 49 ++++
 rtl/cw_div_meter.sv | 180 ++++++++++++++++++
 tb/tb_cw_div_meter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cw_div_pkg.sv
// Shared definitions for the clock-ratio meter: FSM state encoding,
// the legal LOCK_CNT range and the default counter width.
package cw_div_pkg;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } meter_state_e;

  // Default width of period / high-time counters.
  localparam int WIDE_DEFAULT = 32;

  // The lock run counter is 4 bits wide, so the lock depth must fit in it.
  localparam int RUN_W        = 4;
  localparam int LOCK_CNT_MIN = 2;
  localparam int LOCK_CNT_MAX = 15;

endpackage

// File: rtl/cw_edge_detect.sv
// Sampling front end for the measured clock: optional two-flop synchronizer
// followed by the sample register s and its delayed copy, plus rising-edge
// detection. Build option: CW_DIV_METER_SYNC_EN adds the synchronizer so the
// input may be asynchronous to i_Clk (two extra cycles of detection latency).
module cw_edge_detect (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Sig,
  output logic o_S,
  output logic o_Rise
);

  logic sig_in;
  logic s_q;
  logic s_dly_q;

`ifdef CW_DIV_METER_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for an input from a foreign clock domain.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_Sig};
    end
  end

  assign sig_in = sync_q[1];
`else
  // Input is produced from i_Clk already; a single sample register suffices.
  assign sig_in = i_Sig;
`endif

  // Sample register and its one-cycle-delayed copy for edge detection.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      s_q     <= sig_in;
      s_dly_q <= s_q;
    end
  end

  assign o_S    = s_q;
  assign o_Rise = s_q & ~s_dly_q;

endmodule

// File: rtl/cw_div_meter.sv
// Clock-ratio meter: measures the period and high time (in i_Clk cycles) of
// a divided clock, reports each capture with a one-cycle o_Valid pulse, flags
// lock after LOCK_CNT consecutive equal periods and a sticky timeout when the
// input stops toggling. Build option: CW_DIV_METER_SYNC_EN (see cw_edge_detect).
module cw_div_meter
  import cw_div_pkg::*;
#(
  parameter int WIDE     = WIDE_DEFAULT,
  parameter int LOCK_CNT = 4
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic            i_Enable,
  input  logic            i_Sig,
  output logic [WIDE-1:0] o_Div,
  output logic [WIDE-1:0] o_High,
  output logic            o_Valid,
  output logic            o_Lock,
  output logic            o_Timeout
);

  // Reject lock depths that the 4-bit run counter cannot represent.
  generate
    if ((LOCK_CNT < LOCK_CNT_MIN) || (LOCK_CNT > LOCK_CNT_MAX)) begin : g_bad_lock_cnt
      $error("cw_div_meter: LOCK_CNT out of range");
    end
  endgenerate

  localparam logic [WIDE-1:0]  CNT_ONES = '1;
  localparam logic [WIDE-1:0]  CNT_ONE  = {{(WIDE-1){1'b0}}, 1'b1};
  localparam logic [RUN_W-1:0] LOCK_V   = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};

  logic s;
  logic rise;

  meter_state_e     state_q, state_d;
  logic [WIDE-1:0]  cnt_q,   cnt_d;
  logic [WIDE-1:0]  hcnt_q,  hcnt_d;
  logic [WIDE-1:0]  div_q,   div_d;
  logic [WIDE-1:0]  high_q,  high_d;
  logic             valid_q, valid_d;
  logic             lock_q,  lock_d;
  logic             tmo_q,   tmo_d;
  logic [RUN_W-1:0] run_q,   run_d;
  // Set between ARM exit and the first capture: that capture has no
  // previous period of this run to compare against.
  logic             first_q, first_d;

  cw_edge_detect u_edge (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Sig   (i_Sig),
    .o_S     (s),
    .o_Rise  (rise)
  );

  // Next-state and output logic of the measurement FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    div_d   = div_q;
    high_d  = high_q;
    valid_d = 1'b0;
    lock_d  = lock_q;
    tmo_d   = tmo_q;
    run_d   = run_q;
    first_d = first_q;

    if (!i_Enable) begin
      // Disabling drops all status but keeps the last measurement visible.
      state_d = ST_IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
      lock_d  = 1'b0;
      tmo_d   = 1'b0;
      run_d   = '0;
      first_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          hcnt_d  = '0;
          state_d = ST_ARM;
        end

        ST_ARM: begin
          if (rise) begin
            // First edge only opens the measurement window.
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            first_d = 1'b1;
            state_d = ST_MEAS;
          end else if (cnt_q == CNT_ONES) begin
            // No edge at all: report and re-arm with a fresh window.
            tmo_d  = 1'b1;
            lock_d = 1'b0;
            run_d  = '0;
            cnt_d  = '0;
            hcnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_MEAS: begin
          if (rise) begin
            // Capture the finished period; the edge also starts the next one.
            div_d   = cnt_q;
            high_d  = hcnt_q;
            valid_d = 1'b1;
            tmo_d   = 1'b0;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            first_d = 1'b0;
            if (first_q) begin
              run_d = RUN_ONE;
            end else if (cnt_q == div_q) begin
              run_d = (run_q >= LOCK_V) ? LOCK_V : run_q + RUN_ONE;
            end else begin
              run_d = RUN_ONE;
            end
            lock_d = (run_d == LOCK_V);
          end else if (cnt_q == CNT_ONES) begin
            tmo_d   = 1'b1;
            lock_d  = 1'b0;
            run_d   = '0;
            cnt_d   = '0;
            hcnt_d  = '0;
            state_d = ST_ARM;
          end else begin
            cnt_d = (cnt_q == CNT_ONES) ? cnt_q : cnt_q + CNT_ONE;
            if (s && (hcnt_q != CNT_ONES)) begin
              hcnt_d = hcnt_q + CNT_ONE;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      div_q   <= '0;
      high_q  <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      tmo_q   <= 1'b0;
      run_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      div_q   <= div_d;
      high_q  <= high_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
      run_q   <= run_d;
      first_q <= first_d;
    end
  end

  assign o_Div     = div_q;
  assign o_High    = high_q;
  assign o_Valid   = valid_q;
  assign o_Lock    = lock_q;
  assign o_Timeout = tmo_q;

endmodule

// File: tb/tb_cw_div_meter.sv
// Self-checking bench for cw_div_meter (WIDE=8, LOCK_CNT=4). A timestamp-based
// reference model derives captures from the rising-edge times of the driven
// waveform; directed checks cover the ratio-8, ratio-switch, timeout,
// enable-drop and reset scenarios, followed by randomized segments.
module tb_cw_div_meter;

  localparam int W    = 8;
  localparam int LC   = 4;
  localparam int MAXC = 16384;
`ifdef CW_DIV_METER_SYNC_EN
  localparam int SD = 4;   // input-to-sample delay in cycles
`else
  localparam int SD = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         sig;
  logic [W-1:0] o_div;
  logic [W-1:0] o_high;
  logic         o_valid;
  logic         o_lock;
  logic         o_tmo;

  always #5 clk = ~clk;

  cw_div_meter #(.WIDE(W), .LOCK_CNT(LC)) dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_Enable  (en),
    .i_Sig     (sig),
    .o_Div     (o_div),
    .o_High    (o_high),
    .o_Valid   (o_valid),
    .o_Lock    (o_lock),
    .o_Timeout (o_tmo)
  );

  int n_checks = 0;
  int n_err    = 0;
  int c        = 0;

  logic v_h [MAXC];
  logic e_h [MAXC];
  logic r_h [MAXC];
  logic s_h [MAXC];

  // Reference model state (time-stamp based).
  bit           m_active    = 1'b0;
  int           m_last_rise = -1;
  int           m_deadline  = 0;
  int           m_periods[$];
  logic [W-1:0] m_div   = '0;
  logic [W-1:0] m_high  = '0;
  logic         m_valid = 1'b0;
  logic         m_lock  = 1'b0;
  logic         m_tmo   = 1'b0;

  // Observations of the DUT used by the directed checks.
  int   dut_vcnt      = 0;
  int   last_valid_cy = 0;
  int   tmo_rise_cy   = 0;
  logic prev_tmo      = 1'b0;
  logic en_cur        = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, c, got, exp);
    end
  endtask

  // Model of one clock edge k: inputs driven before edge k-1 reach the
  // sample register SD edges late; periods are rise-time differences and
  // high time is the number of high samples since the previous rise.
  function automatic void model_edge(input int k);
    logic s, sd, rise;
    int   p, h;
    s    = (k >= SD)     ? v_h[k-SD]   : 1'b0;
    sd   = (k >= SD + 1) ? v_h[k-SD-1] : 1'b0;
    rise = s & ~sd;
    s_h[k] = s;
    m_valid = 1'b0;
    if (!r_h[k-1]) begin
      m_active = 1'b0; m_last_rise = -1; m_periods.delete();
      m_div = '0; m_high = '0; m_lock = 1'b0; m_tmo = 1'b0;
    end else if (!e_h[k-1]) begin
      m_active = 1'b0; m_last_rise = -1; m_periods.delete();
      m_lock = 1'b0; m_tmo = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_last_rise = -1; m_periods.delete();
      m_deadline = k + (1 << W);
    end else if (rise) begin
      if (m_last_rise >= 0) begin
        p = k - m_last_rise;
        h = 0;
        for (int t = m_last_rise; t < k; t++) h += int'(s_h[t]);
        m_div = p[W-1:0]; m_high = h[W-1:0]; m_valid = 1'b1; m_tmo = 1'b0;
        m_periods.push_back(p);
        m_lock = (m_periods.size() >= LC);
        if (m_lock)
          for (int i = 1; i < LC; i++)
            if (m_periods[m_periods.size()-1-i] != p) m_lock = 1'b0;
      end
      m_last_rise = k;
      m_deadline  = k + (1 << W) - 1;
    end else if (k == m_deadline) begin
      m_tmo = 1'b1; m_lock = 1'b0; m_last_rise = -1; m_periods.delete();
      m_deadline = k + (1 << W);
    end
  endfunction

  task automatic step(input logic sg, input logic ena, input logic rs);
    if (c >= MAXC - 2) begin
      $display("FAIL cycle_budget cyc=%0d got=over expected=under %0d", c, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    v_h[c] = sg; e_h[c] = ena; r_h[c] = rs;
    sig = sg; en = ena; rst_n = rs;
    @(posedge clk);
    c++;
    model_edge(c);
    @(negedge clk);
    check("valid",   32'(o_valid), 32'(m_valid));
    check("lock",    32'(o_lock),  32'(m_lock));
    check("timeout", 32'(o_tmo),   32'(m_tmo));
    check("div",     32'(o_div),   32'(m_div));
    check("high",    32'(o_high),  32'(m_high));
    if (o_valid) begin
      dut_vcnt++;
      last_valid_cy = c;
      $display("capture cyc=%0d div=%0d high=%0d lock=%0b timeout=%0b",
               c, o_div, o_high, o_lock, o_tmo);
    end
    if (o_tmo && !prev_tmo) tmo_rise_cy = c;
    prev_tmo = o_tmo;
  endtask

  // n_per periods of an N-cycle clock that is high for the first H cycles.
  task automatic clk_run(input int n_per, input int n, input int h);
    for (int p = 0; p < n_per; p++)
      for (int i = 0; i < n; i++)
        step(i < h, en_cur, 1'b1);
  endtask

  initial begin
    int v0, n, h;

    // Reset state.
    repeat (4) step(1'b0, 1'b0, 1'b0);
    check("rst_div",   32'(o_div),   32'd0);
    check("rst_high",  32'(o_high),  32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_lock",  32'(o_lock),  32'd0);
    check("rst_tmo",   32'(o_tmo),   32'd0);
    repeat (SD + 2) step(1'b0, 1'b0, 1'b1);

    // Ratio 8, 4 high / 4 low: 8 periods give 7 captures, locked.
    en_cur = 1'b1;
    repeat ($urandom_range(0, 5)) step(1'b0, 1'b1, 1'b1);
    v0 = dut_vcnt;
    clk_run(8, 8, 4);
    check("r8_caps", 32'(dut_vcnt - v0), 32'd7);
    check("r8_div",  32'(o_div),  32'd8);
    check("r8_high", 32'(o_high), 32'd4);
    check("r8_lock", 32'(o_lock), 32'd1);

    // Switch to ratio 6: first 6-capture drops lock, three more relock.
    clk_run(2, 6, 3);
    check("r6_div",    32'(o_div),  32'd6);
    check("r6_unlock", 32'(o_lock), 32'd0);
    clk_run(3, 6, 3);
    check("r6_high",   32'(o_high), 32'd3);
    check("r6_relock", 32'(o_lock), 32'd1);

    // Input stuck low: timeout 255 cycles after the last restart.
    repeat (300) step(1'b0, 1'b1, 1'b1);
    check("tmo_set",   32'(o_tmo),  32'd1);
    check("tmo_lock",  32'(o_lock), 32'd0);
    check("tmo_delay", 32'(tmo_rise_cy - last_valid_cy), 32'd255);
    clk_run(3, 8, 4);
    check("tmo_clear", 32'(o_tmo), 32'd0);
    check("tmo_div",   32'(o_div), 32'd8);

    // Enable dropped mid-period while locked.
    clk_run(4, 8, 4);
    check("pre_dis_lock", 32'(o_lock), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("dis_lock",  32'(o_lock),  32'd0);
    check("dis_valid", 32'(o_valid), 32'd0);
    check("dis_div",   32'(o_div),   32'd8);
    for (int i = 4; i < 8; i++) step(1'b0, 1'b0, 1'b1);
    en_cur = 1'b1;
    v0 = dut_vcnt;
    clk_run(1, 8, 4);
    check("reen_nocap", 32'(dut_vcnt - v0), 32'd0);
    clk_run(1, 8, 4);
    check("reen_cap",   32'(dut_vcnt - v0), 32'd1);

    // One-cycle reset in the middle of a measurement.
    clk_run(1, 8, 4);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("mrst_div",   32'(o_div),   32'd0);
    check("mrst_high",  32'(o_high),  32'd0);
    check("mrst_valid", 32'(o_valid), 32'd0);
    check("mrst_lock",  32'(o_lock),  32'd0);
    repeat (SD + 2) step(1'b0, 1'b0, 1'b1);

    // Randomized segments: ratios, duty, enable gaps and stuck periods.
    for (int seg = 0; seg < 14; seg++) begin
      n = $urandom_range(2, 24);
      h = $urandom_range(1, n - 1);
      en_cur = ($urandom_range(0, 5) != 0);
      clk_run($urandom_range(2, 8), n, h);
      if ($urandom_range(0, 6) == 0)
        repeat ($urandom_range(200, 280)) step(1'b0, en_cur, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
